// File: rtl/det_1011.sv
// rtl/det_1011.sv - Mealy serial detector for the overlapping bit pattern 1011
module det_1011 (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);

  // Progress through the pattern, named by the suffix matched so far
  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  state_t state;

  // Advance pattern progress one bit per clock; on a miss, fall back to the longest reusable suffix
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S0;
    end else begin
      case (state)
        S0:      state <= in ? S1   : S0;
        S1:      state <= in ? S1   : S10;
        S10:     state <= in ? S101 : S0;
        S101:    state <= in ? S1   : S10;
        default: state <= S0;
      endcase
    end
  end

  // Detect flag follows the live input so the match is flagged in the same cycle as the final 1
  assign out = rstn & (state == S101) & in;

endmodule

// File: tb/tb_det_1011.sv
// tb/tb_det_1011.sv - self-checking bench for det_1011
module tb_det_1011;

  logic clk;
  logic rstn;
  logic in_bit;
  logic out_bit;

  int tests_run;
  int tests_failed;

  // Every bit consumed since the last reset, oldest first
  bit hist[$];

  det_1011 dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in_bit),
    .out  (out_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the bits since reset plus the current input end in 1,0,1,1
  function automatic logic model_match(input logic b);
    int n;
    n = hist.size();
    if (n < 3) return 1'b0;
    return (hist[n-3] == 1'b1) && (hist[n-2] == 1'b0) && (hist[n-1] == 1'b1) && (b == 1'b1);
  endfunction

  // Present one bit between edges, sample the flag, and record the bit as consumed by the next edge
  task automatic step(input logic b, output logic obs);
    @(negedge clk);
    in_bit = b;
    #1;
    obs = out_bit;
    hist.push_back(b);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    in_bit = 1'b0;
    hist.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic obs;
    @(negedge clk);
    rstn = 1'b0;
    hist.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_bit = i[0];
      #1;
      tests_run++;
      if (out_bit !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: out=%b expected 0", i, out_bit);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, obs);
    tests_run++;
    if (obs !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: out=%b expected 0", obs);
    end
  endtask

  task automatic test_directed();
    logic obs;
    logic exp;
    logic [10:0] stim;
    stim = 11'b10101101011;
    apply_reset();
    for (int i = 1; i <= 11; i++) begin
      step(stim[11-i], obs);
      exp = (i == 6) || (i == 11);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL directed bit %0d: out=%b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_overlap();
    logic obs;
    logic exp;
    logic [6:0] stim;
    stim = 7'b1011011;
    apply_reset();
    for (int i = 1; i <= 7; i++) begin
      step(stim[7-i], obs);
      exp = (i == 4) || (i == 7);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL overlap bit %0d: out=%b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_near_miss();
    logic obs;
    logic [4:0] pats [4];
    int lens [4];
    pats[0] = 5'b01111; lens[0] = 4;
    pats[1] = 5'b00000; lens[1] = 4;
    pats[2] = 5'b10011; lens[2] = 5;
    pats[3] = 5'b11010; lens[3] = 5;
    for (int p = 0; p < 4; p++) begin
      apply_reset();
      for (int i = lens[p] - 1; i >= 0; i--) begin
        step(pats[p][i], obs);
        tests_run++;
        if (obs !== 1'b0) begin
          tests_failed++;
          $display("FAIL near_miss pattern %0d bit %0d: out=%b expected 0", p, lens[p] - i, obs);
        end
      end
    end
  endtask

  task automatic test_async_reset_mid();
    logic obs;
    logic [2:0] tail;
    apply_reset();
    step(1'b1, obs);
    step(1'b0, obs);
    step(1'b1, obs);
    // Reset pulse strictly between edges with the completing bit already present
    @(negedge clk);
    in_bit = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (out_bit !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_low: out=%b expected 0", out_bit);
    end
    #1;
    rstn = 1'b1;
    hist.delete();
    #1;
    tests_run++;
    if (out_bit !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_discard: out=%b expected 0", out_bit);
    end
    hist.push_back(1'b1);
    tail = 3'b011;
    for (int i = 2; i >= 0; i--) begin
      step(tail[i], obs);
      tests_run++;
      if (obs !== (i == 0)) begin
        tests_failed++;
        $display("FAIL async_reset_restart bit %0d: out=%b expected %b", 3 - i, obs, (i == 0));
      end
    end
  endtask

  task automatic test_random();
    logic obs;
    logic exp;
    logic b;
    int hold;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      b = 1'($urandom_range(0, 1));
      hold = 1 + $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        exp = model_match(b);
        step(b, obs);
        tests_run++;
        if (obs !== exp) begin
          tests_failed++;
          $display("FAIL random bit %0d hold %0d: out=%b expected %b", i, h, obs, exp);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rstn = 1'b0;
    in_bit = 1'b0;
    test_reset();
    test_directed();
    test_overlap();
    test_near_miss();
    test_async_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
